// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, LSB-first shift with odd parity
// and stop, device ACK check, with a timeout from clock release back to idle.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int REQ_CYCLES     = 250,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       iCLK_50,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
   localparam logic [PH_W-1:0] REQ_LAST = PH_W'(REQ_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

   state_t            state, state_next;
   logic [7:0]        data_reg;
   logic              parity_reg;
   logic [3:0]        bit_cnt;
   logic [PH_W-1:0]   ph_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              dat_bit;
   logic              ack_ok;
   logic              clk_s1, clk_s2, clk_prev;
   logic              dat_s1, dat_s2;
   logic              clk_fall;
   logic              timeout;
   logic              accept;
   logic              finish;
   logic              finish_err;

   assign clk_fall = clk_prev & ~clk_s2;
   assign timeout  = (to_cnt == TO_LAST);
   assign tx_ready = (state == IDLE);

   always_ff @(posedge iCLK_50 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // The timeout overrides everything else once the host has released the clock.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      finish_err = 1'b0;
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      case (state)
         IDLE: begin
            if (tx_valid) begin
               accept     = 1'b1;
               state_next = INHIBIT;
            end
         end
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (ph_cnt == INH_LAST) state_next = REQ;
         end
         REQ: begin
            ps2_clk_oe = 1'b1;
            ps2_dat_oe = 1'b1;
            if (ph_cnt == REQ_LAST) state_next = SHIFT;
         end
         SHIFT: begin
            ps2_dat_oe = dat_bit;
            if (clk_fall && bit_cnt == 4'd9) state_next = ACK;
         end
         ACK: begin
            if (clk_fall) state_next = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (clk_s2 && dat_s2) begin
               state_next = IDLE;
               finish     = 1'b1;
               finish_err = ~ack_ok;
            end
         end
         default: state_next = IDLE;
      endcase
      if ((state inside {SHIFT, ACK, WAIT_IDLE}) && timeout) begin
         state_next = IDLE;
         finish     = 1'b1;
         finish_err = 1'b1;
         ps2_dat_oe = 1'b0;
      end
   end

   // Synchronizers idle high so a released bus never looks like a clock fall.
   always_ff @(posedge iCLK_50 or posedge reset) begin
      if (reset) begin
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         clk_prev   <= 1'b1;
         dat_s1     <= 1'b1;
         dat_s2     <= 1'b1;
         data_reg   <= '0;
         parity_reg <= 1'b0;
         bit_cnt    <= '0;
         ph_cnt     <= '0;
         to_cnt     <= '0;
         dat_bit    <= 1'b0;
         ack_ok     <= 1'b0;
         tx_done    <= 1'b0;
         tx_err     <= 1'b0;
      end else begin
         clk_s1   <= ps2_clk_in;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_dat_in;
         dat_s2   <= dat_s1;
         tx_done  <= finish;

         if (accept) begin
            data_reg   <= tx_data;
            parity_reg <= ~^tx_data;
            tx_err     <= 1'b0;
         end else if (finish) begin
            tx_err <= finish_err;
         end

         if (state == INHIBIT && state_next == REQ)   ph_cnt <= '0;
         else if (state == INHIBIT || state == REQ)   ph_cnt <= ph_cnt + 1'b1;
         else                                         ph_cnt <= '0;

         // The start bit stays on the line until the device's first clock fall.
         if (state == REQ) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
            dat_bit <= 1'b1;
         end else if (state inside {SHIFT, ACK, WAIT_IDLE}) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (state == SHIFT && clk_fall) begin
            if (bit_cnt < 4'd8)       dat_bit <= ~data_reg[bit_cnt[2:0]];
            else if (bit_cnt == 4'd8) dat_bit <= ~parity_reg;
            else                      dat_bit <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (state == ACK && clk_fall) ack_ok <= ~dat_s2;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device model on open-drain
// lines, a table of byte vectors plus random bytes, and hand-written corner cases.
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int RQ  = 5;
   localparam int TO  = 3000;

   logic       iCLK_50 = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_done, tx_err;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       glitch_low  = 1'b0;

   int checks     = 0;
   int errors     = 0;
   int done_count = 0;
   int cyc        = 0;

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         exp_err;
   } vec_t;

   vec_t vecs[6];

   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(RQ), .TIMEOUT_CYCLES(TO)) dut (
      .iCLK_50   (iCLK_50),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_done   (tx_done),
      .tx_err    (tx_err),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe)
   );

   always #5 iCLK_50 = ~iCLK_50;

   always @(posedge iCLK_50) cyc++;
   always @(negedge iCLK_50) if (tx_done) done_count++;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   // Frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] expFrame(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge iCLK_50);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge iCLK_50);
      tx_valid = 1'b0;
   endtask

   task automatic deviceFrame(input bit give_ack, input int stop_after,
                              output logic [10:0] frame, output int inh_cnt,
                              output int req_cnt, output int rel_cyc);
      int guard;
      frame   = '0;
      inh_cnt = 0;
      req_cnt = 0;
      guard   = 0;
      while (!(ps2_clk_oe && !ps2_dat_oe) && guard < 1000) begin
         @(negedge iCLK_50);
         guard++;
      end
      while (ps2_clk_oe && !ps2_dat_oe && guard < 2000) begin
         inh_cnt++;
         @(negedge iCLK_50);
         guard++;
      end
      while (ps2_clk_oe && ps2_dat_oe && guard < 3000) begin
         req_cnt++;
         @(negedge iCLK_50);
         guard++;
      end
      rel_cyc  = cyc;
      frame[0] = ps2_dat_in;
      repeat (10) @(negedge iCLK_50);
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1;
         repeat (20) @(negedge iCLK_50);
         dev_clk_low = 1'b0;
         frame[i] = ps2_dat_in;
         repeat (20) @(negedge iCLK_50);
         if (stop_after == i) return;
      end
      dev_dat_low = give_ack;
      repeat (5) @(negedge iCLK_50);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge iCLK_50);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge iCLK_50);
      dev_dat_low = 1'b0;
   endtask

   task automatic waitDone(output int done_cyc, output bit got, output logic r_at,
                           output logic e_at, output logic c_at, output logic d_at);
      got = 1'b0;
      done_cyc = 0;
      r_at = 1'b0; e_at = 1'b0; c_at = 1'b0; d_at = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge iCLK_50);
         if (tx_done) begin
            got      = 1'b1;
            done_cyc = cyc;
            r_at     = tx_ready;
            e_at     = tx_err;
            c_at     = ps2_clk_oe;
            d_at     = ps2_dat_oe;
            break;
         end
      end
   endtask

   task automatic runVector(input vec_t v);
      logic [10:0] frame;
      int inh, req, rel, dcyc, dc0;
      bit got;
      logic r_at, e_at, c_at, d_at;
      dc0 = done_count;
      applyStimulus(v.data);
      checkOutput("vec_busy", tx_ready, 1'b0);
      checkOutput("vec_err_cleared", tx_err, 1'b0);
      fork
         deviceFrame(v.ack, 0, frame, inh, req, rel);
         waitDone(dcyc, got, r_at, e_at, c_at, d_at);
      join
      checkOutput("vec_inhibit_len", inh, INH);
      checkOutput("vec_req_len", req, RQ);
      checkOutput("vec_frame", frame, expFrame(v.data));
      checkOutput("vec_done_seen", got, 1'b1);
      checkOutput("vec_err_at_done", e_at, v.exp_err);
      checkOutput("vec_ready_at_done", r_at, 1'b1);
      repeat (3) @(negedge iCLK_50);
      checkOutput("vec_done_once", done_count - dc0, 1);
      checkOutput("vec_err_held", tx_err, v.exp_err);
   endtask

   initial begin
      logic [10:0] f1, f2;
      int inh1, req1, rel1, inh2, req2, rel2, dcyc, dc0, guard;
      bit got;
      logic r_at, e_at, c_at, d_at;

      vecs[0] = '{data: 8'hFF, ack: 1'b1, exp_err: 1'b0};
      vecs[1] = '{data: 8'h00, ack: 1'b1, exp_err: 1'b0};
      vecs[2] = '{data: 8'hF4, ack: 1'b0, exp_err: 1'b1};
      vecs[3] = '{data: 8'h80, ack: 1'b1, exp_err: 1'b0};
      for (int i = 4; i < 6; i++) begin
         vecs[i].data    = 8'($urandom_range(0, 255));
         vecs[i].ack     = 1'($urandom_range(0, 1));
         vecs[i].exp_err = ~vecs[i].ack;
      end

      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge iCLK_50);
      checkOutput("rst_ready", tx_ready, 1'b1);
      checkOutput("rst_done", tx_done, 1'b0);
      checkOutput("rst_err", tx_err, 1'b0);
      checkOutput("rst_clk_oe", ps2_clk_oe, 1'b0);
      checkOutput("rst_dat_oe", ps2_dat_oe, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge iCLK_50);

      for (int i = 0; i < 6; i++) runVector(vecs[i]);

      // Back to back: tx_valid held, second byte taken on the first ready cycle.
      $display("[TB] back-to-back 0xED, 0x02");
      dc0 = done_count;
      @(negedge iCLK_50);
      tx_data  = 8'hED;
      tx_valid = 1'b1;
      fork
         deviceFrame(1'b1, 0, f1, inh1, req1, rel1);
         waitDone(dcyc, got, r_at, e_at, c_at, d_at);
      join
      tx_data = 8'h02;
      checkOutput("b2b_first_done", got, 1'b1);
      checkOutput("b2b_first_err", e_at, 1'b0);
      checkOutput("b2b_first_frame", f1, expFrame(8'hED));
      @(negedge iCLK_50);
      checkOutput("b2b_second_accepted", tx_ready, 1'b0);
      tx_valid = 1'b0;
      fork
         deviceFrame(1'b1, 0, f2, inh2, req2, rel2);
         waitDone(dcyc, got, r_at, e_at, c_at, d_at);
      join
      checkOutput("b2b_second_done", got, 1'b1);
      checkOutput("b2b_second_err", e_at, 1'b0);
      checkOutput("b2b_second_inhibit", inh2, INH);
      checkOutput("b2b_second_frame", f2, expFrame(8'h02));
      repeat (3) @(negedge iCLK_50);
      checkOutput("b2b_done_count", done_count - dc0, 2);

      // Device stops clocking after four falls: only the timeout ends the transfer.
      $display("[TB] timeout 0x55");
      applyStimulus(8'h55);
      fork
         deviceFrame(1'b1, 4, f1, inh1, req1, rel1);
         waitDone(dcyc, got, r_at, e_at, c_at, d_at);
      join
      checkOutput("to_done_seen", got, 1'b1);
      checkOutput("to_latency", dcyc - rel1, TO);
      checkOutput("to_err", e_at, 1'b1);
      checkOutput("to_ready", r_at, 1'b1);
      checkOutput("to_clk_oe", c_at, 1'b0);
      checkOutput("to_dat_oe", d_at, 1'b0);

      // Reset mid-shift after five falls: bit 4 of 0x0F (a zero) is on the line.
      $display("[TB] reset during shift");
      applyStimulus(8'h0F);
      deviceFrame(1'b1, 5, f1, inh1, req1, rel1);
      checkOutput("mid_dat_oe", ps2_dat_oe, 1'b1);
      checkOutput("mid_clk_oe", ps2_clk_oe, 1'b0);
      dc0 = done_count;
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_dat_oe", ps2_dat_oe, 1'b0);
      checkOutput("async_rst_done", tx_done, 1'b0);
      checkOutput("async_rst_ready", tx_ready, 1'b1);
      @(negedge iCLK_50);
      reset = 1'b0;
      repeat (5) @(negedge iCLK_50);
      checkOutput("abort_no_done", done_count - dc0, 0);
      runVector('{data: 8'hF4, ack: 1'b1, exp_err: 1'b0});

      // Stray request during INHIBIT and a clock glitch during REQ must both be ignored.
      $display("[TB] stray request and glitch");
      dc0 = done_count;
      applyStimulus(8'h5A);
      fork
         deviceFrame(1'b1, 0, f1, inh1, req1, rel1);
         waitDone(dcyc, got, r_at, e_at, c_at, d_at);
         begin
            repeat (5) @(negedge iCLK_50);
            tx_data  = 8'h11;
            tx_valid = 1'b1;
            @(negedge iCLK_50);
            tx_valid = 1'b0;
            guard = 0;
            while (!(ps2_clk_oe && ps2_dat_oe) && guard < 100) begin
               @(negedge iCLK_50);
               guard++;
            end
            @(negedge iCLK_50);
            glitch_low = 1'b1;
            @(negedge iCLK_50);
            glitch_low = 1'b0;
         end
      join
      checkOutput("glitch_inhibit", inh1, INH);
      checkOutput("glitch_req", req1, RQ);
      checkOutput("glitch_frame", f1, expFrame(8'h5A));
      checkOutput("glitch_err", e_at, 1'b0);
      repeat (50) @(negedge iCLK_50);
      checkOutput("stray_ignored_done", done_count - dc0, 1);
      checkOutput("stray_ignored_ready", tx_ready, 1'b1);
      checkOutput("stray_ignored_clk_oe", ps2_clk_oe, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
